// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: fetch-side enqueue port and decoder-side dequeue port, plus occupancy.
// Each handshake transfers only on a rising edge where valid and ready are both high.
`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif

interface fetch_queue_if #(
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic                         in_valid;
    logic                         in_ready;
    logic [`DATA_SIZE-1:0]        in_word;
    logic [`DATA_SIZE-1:0]        in_pc;
    logic                         out_valid;
    logic                         out_ready;
    logic [`INSTRUCTION_SIZE-1:0] out_instruction;
    logic [`DATA_SIZE-1:0]        out_pc;
    logic [PTR_W:0]               count;

    // master is the fetch/decode environment, slave is the queue itself
    modport master (
        output in_valid, in_word, in_pc, out_ready,
        input  in_ready, out_valid, out_instruction, out_pc, count
    );
    modport slave (
        input  in_valid, in_word, in_pc, out_ready,
        output in_ready, out_valid, out_instruction, out_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction buffer: splits aligned 64-bit fetch words into 32-bit instructions and queues them.
// Optional same-cycle bypass into an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    fetch_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [`INSTRUCTION_SIZE-1:0] instr_mem_q [DEPTH];
    logic [`DATA_SIZE-1:0]        pc_mem_q    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             in_ready;
    logic             enq;
    logic             deq;
    logic             two_wide;
    logic             bypass_show;
    logic             bypass_take;
    logic [PTR_W:0]   enq_n;
    logic [PTR_W:0]   deq_n;

    logic                         wr0_en, wr1_en;
    logic [PTR_W-1:0]             wr0_idx, wr1_idx;
    logic [`INSTRUCTION_SIZE-1:0] wr0_instr, wr1_instr;
    logic [`DATA_SIZE-1:0]        wr0_pc, wr1_pc;
    logic [`INSTRUCTION_SIZE-1:0] first_instr, second_instr;
    logic [`DATA_SIZE-1:0]        second_pc;

    assign in_ready     = (DEPTH_CNT - count_q) >= (PTR_W+1)'(2);
    assign two_wide     = ~bus.in_pc[2];
    assign first_instr  = two_wide ? bus.in_word[31:0] : bus.in_word[63:32];
    assign second_instr = bus.in_word[63:32];
    assign second_pc    = bus.in_pc + 64'd4;
    assign enq          = bus.in_valid && in_ready && !flush;
    assign deq          = (count_q != '0) && bus.out_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    // first instruction of a word arriving at an empty queue is shown immediately
    assign bypass_show = enq && (count_q == '0);
    assign bypass_take = bypass_show && bus.out_ready;
`else
    assign bypass_show = 1'b0;
    assign bypass_take = 1'b0;
`endif

    always_comb begin
        wr0_en    = 1'b0;
        wr1_en    = 1'b0;
        wr0_idx   = wr_ptr_q;
        wr1_idx   = wr_ptr_q + PTR_W'(1);
        wr0_instr = first_instr;
        wr0_pc    = bus.in_pc;
        wr1_instr = second_instr;
        wr1_pc    = second_pc;
        if (enq) begin
            if (!bypass_take) begin
                wr0_en = 1'b1;
                wr1_en = two_wide;
            end else if (two_wide) begin
                // first half went straight to the decoder; only the upper half is stored
                wr0_en    = 1'b1;
                wr0_instr = second_instr;
                wr0_pc    = second_pc;
            end
        end
        enq_n = (PTR_W+1)'(wr0_en) + (PTR_W+1)'(wr1_en);
        deq_n = (PTR_W+1)'(deq);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + enq_n[PTR_W-1:0];
            rd_ptr_d = rd_ptr_q + PTR_W'(deq);
            count_d  = count_q + enq_n - deq_n;
        end
    end

    always_comb begin
        bus.in_ready        = in_ready;
        bus.count           = count_q;
        bus.out_valid       = 1'b0;
        bus.out_instruction = '0;
        bus.out_pc          = '0;
        if (count_q != '0) begin
            bus.out_valid       = 1'b1;
            bus.out_instruction = instr_mem_q[rd_ptr_q];
            bus.out_pc          = pc_mem_q[rd_ptr_q];
        end else if (bypass_show) begin
            bus.out_valid       = 1'b1;
            bus.out_instruction = first_instr;
            bus.out_pc          = bus.in_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            instr_mem_q[wr0_idx] <= wr0_instr;
            pc_mem_q[wr0_idx]    <= wr0_pc;
        end
        if (wr1_en) begin
            instr_mem_q[wr1_idx] <= wr1_instr;
            pc_mem_q[wr1_idx]    <= wr1_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner sequences, random vs queue model.
module tb_fetch_queue;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {instruction, pc} in program order
    logic [95:0] exp_q[$];

    typedef struct {
        logic        v;
        logic [63:0] word;
        logic [63:0] pc;
        logic        rdy;
        logic        fl;
        int          e_count;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic v, input logic [63:0] word, input logic [63:0] pc,
                           input logic rdy, input logic fl, input int e_count, input logic e_valid,
                           input logic e_ready, input logic [31:0] e_instr, input logic [63:0] e_pc);
        vec_t r;
        r.v = v; r.word = word; r.pc = pc; r.rdy = rdy; r.fl = fl;
        r.e_count = e_count; r.e_valid = e_valid; r.e_ready = e_ready;
        r.e_instr = e_instr; r.e_pc = e_pc;
        vecs.push_back(r);
    endtask

    // model view of the outputs for the current (pre-edge) inputs
    task automatic model_check(input logic v, input logic [63:0] word, input logic [63:0] pc,
                               input logic fl);
        int          sz;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        sz      = exp_q.size();
        e_ready = (DEPTH - sz) >= 2;
        e_valid = 1'b0;
        e_instr = '0;
        e_pc    = '0;
        if (sz != 0) begin
            e_valid = 1'b1;
            e_instr = exp_q[0][95:64];
            e_pc    = exp_q[0][63:0];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (v && e_ready && !fl) begin
            e_valid = 1'b1;
            e_instr = pc[2] ? word[63:32] : word[31:0];
            e_pc    = pc;
        end
`endif
        chk("model_count", 64'(bus.count), 64'(sz));
        chk("model_in_ready", 64'(bus.in_ready), 64'(e_ready));
        chk("model_out_valid", 64'(bus.out_valid), 64'(e_valid));
        chk("model_out_instruction", 64'(bus.out_instruction), 64'(e_instr));
        chk("model_out_pc", bus.out_pc, e_pc);
    endtask

    task automatic model_step(input logic v, input logic [63:0] word, input logic [63:0] pc,
                              input logic rdy, input logic fl);
        int   sz;
        logic enq;
        logic skip_first;
        sz         = exp_q.size();
        enq        = v && ((DEPTH - sz) >= 2) && !fl;
        skip_first = 1'b0;
        if (fl) begin
            exp_q.delete();
            return;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (enq && sz == 0 && rdy) skip_first = 1'b1;
`endif
        if (sz != 0 && rdy) void'(exp_q.pop_front());
        if (enq) begin
            if (!pc[2]) begin
                if (!skip_first) exp_q.push_back({word[31:0], pc});
                exp_q.push_back({word[63:32], pc + 64'd4});
            end else if (!skip_first) begin
                exp_q.push_back({word[63:32], pc});
            end
        end
    endtask

    // driver: called 1 time unit after a rising edge, returns at the same phase
    task automatic cycle(input logic v, input logic [63:0] word, input logic [63:0] pc,
                         input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_word   = word;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        flush         = fl;
        #1;
        model_check(v, word, pc, fl);
        model_step(v, word, pc, rdy, fl);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        #3;
        chk("reset_count", 64'(bus.count), 64'd0);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        #9 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_out_instruction", 64'(bus.out_instruction), 64'd0);
        chk("post_reset_out_pc", bus.out_pc, 64'd0);

        // v, word, pc, rdy, fl | count, valid, in_ready, instr, pc (after the edge)
        add_vec(1, 64'h00500093_00A00113, 64'h1000, 0, 0, 2, 1, 1, 32'h00A00113, 64'h1000);
        add_vec(0, 64'h0, 64'h0, 1, 0, 1, 1, 1, 32'h00500093, 64'h1004);
        add_vec(0, 64'h0, 64'h0, 1, 0, 0, 0, 1, 32'h0, 64'h0);
        add_vec(1, 64'hDEADBEEF_00000013, 64'h2004, 0, 0, 1, 1, 1, 32'hDEADBEEF, 64'h2004);
        add_vec(1, 64'h11111111_22222222, 64'h3000, 0, 0, 3, 1, 1, 32'hDEADBEEF, 64'h2004);
        add_vec(1, 64'h33333333_44444444, 64'h3008, 0, 0, 5, 1, 1, 32'hDEADBEEF, 64'h2004);
        add_vec(1, 64'h55555555_66666666, 64'h3010, 1, 0, 6, 1, 1, 32'h22222222, 64'h3000);
        add_vec(1, 64'h77777777_88888888, 64'h3018, 1, 0, 7, 1, 0, 32'h11111111, 64'h3004);
        add_vec(1, 64'h99999999_AAAAAAAA, 64'h4000, 0, 0, 7, 1, 0, 32'h11111111, 64'h3004);
        add_vec(0, 64'h0, 64'h0, 1, 0, 6, 1, 1, 32'h44444444, 64'h3008);
        add_vec(0, 64'h0, 64'h0, 1, 0, 5, 1, 1, 32'h33333333, 64'h300C);
        add_vec(0, 64'h0, 64'h0, 1, 0, 4, 1, 1, 32'h66666666, 64'h3010);
        add_vec(0, 64'h0, 64'h0, 1, 0, 3, 1, 1, 32'h55555555, 64'h3014);
        add_vec(0, 64'h0, 64'h0, 1, 0, 2, 1, 1, 32'h88888888, 64'h3018);
        add_vec(0, 64'h0, 64'h0, 1, 0, 1, 1, 1, 32'h77777777, 64'h301C);
        add_vec(0, 64'h0, 64'h0, 1, 0, 0, 0, 1, 32'h0, 64'h0);
        add_vec(1, 64'hA0000001_B0000001, 64'h5000, 0, 0, 2, 1, 1, 32'hB0000001, 64'h5000);
        add_vec(1, 64'hA0000002_B0000002, 64'h5008, 0, 0, 4, 1, 1, 32'hB0000001, 64'h5000);
        add_vec(1, 64'hA0000003_B0000003, 64'h5010, 0, 0, 6, 1, 1, 32'hB0000001, 64'h5000);
        add_vec(1, 64'hA0000004_B0000004, 64'h5018, 0, 0, 8, 1, 0, 32'hB0000001, 64'h5000);
        add_vec(1, 64'hCCCCCCCC_DDDDDDDD, 64'h6000, 0, 0, 8, 1, 0, 32'hB0000001, 64'h5000);
        add_vec(0, 64'h0, 64'h0, 1, 0, 7, 1, 0, 32'hA0000001, 64'h5004);
        add_vec(0, 64'h0, 64'h0, 1, 0, 6, 1, 1, 32'hB0000002, 64'h5008);
        add_vec(0, 64'h0, 64'h0, 1, 0, 5, 1, 1, 32'hA0000002, 64'h500C);
        add_vec(1, 64'hEEEEEEEE_FFFFFFFF, 64'h7000, 1, 1, 0, 0, 1, 32'h0, 64'h0);

        foreach (vecs[i]) begin
            cycle(vecs[i].v, vecs[i].word, vecs[i].pc, vecs[i].rdy, vecs[i].fl);
            chk($sformatf("vec%0d_count", i), 64'(bus.count), 64'(vecs[i].e_count));
            chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_valid));
            chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].e_ready));
            chk($sformatf("vec%0d_out_instruction", i), 64'(bus.out_instruction), 64'(vecs[i].e_instr));
            chk($sformatf("vec%0d_out_pc", i), bus.out_pc, vecs[i].e_pc);
        end

        // asynchronous reset between edges with three entries queued
        cycle(1, 64'h12345678_9ABCDEF0, 64'h8000, 0, 0);
        cycle(1, 64'h0BADF00D_FFFFFFFF, 64'h8014, 0, 0);
        chk("pre_async_count", 64'(bus.count), 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_count", 64'(bus.count), 64'd0);
        chk("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_reset_out_instruction", 64'(bus.out_instruction), 64'd0);
        #1 reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;

`ifdef FETCH_QUEUE_BYPASS_EN
        bus.in_valid  = 1'b1;
        bus.in_word   = 64'h00200093_00100113;
        bus.in_pc     = 64'h3000;
        bus.out_ready = 1'b1;
        #1;
        chk("bypass_same_cycle_valid", 64'(bus.out_valid), 64'd1);
        chk("bypass_same_cycle_instruction", 64'(bus.out_instruction), 64'h00100113);
        cycle(1, 64'h00200093_00100113, 64'h3000, 1, 0);
        chk("bypass_count_after", 64'(bus.count), 64'd1);
        chk("bypass_head_after", 64'(bus.out_instruction), 64'h00200093);
`endif

        // randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            logic [63:0] r_word;
            logic [63:0] r_pc;
            r_word = {$urandom, $urandom};
            r_pc   = {$urandom, $urandom} & ~64'h3;
            cycle(($urandom_range(0, 3) != 0), r_word, r_pc,
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 29) == 0));
        end
        #1;
        model_check(1'b0, 64'h0, 64'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
